// File: rtl/array_rw_pkg.sv
// array_rw_pkg: shared types and constants for the array_rw_ctrl slice.
//   DEPTH / ADDR_W / DATA_W : geometry of the 128x76 single-port RW macro.
//   STARVE_LIMIT            : consecutive read-winning cycles before a buffered
//                             write is forced onto the port.
//   state_e                 : controller FSM states (INIT sweep, RUN).
//   wbuf_t                  : one buffered write (address, bit mask, data).
package array_rw_pkg;

  localparam int DEPTH  = 128;
  localparam int ADDR_W = 7;
  localparam int DATA_W = 76;

  localparam logic [1:0] STARVE_LIMIT = 2'd3;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] mask;
    logic [DATA_W-1:0] data;
  } wbuf_t;

endpackage

// File: rtl/array_rw_ctrl_if.sv
// array_rw_ctrl_if: request/response channels plus the RW0 macro port.
//   rd_req_*  : read request (valid/ready, address)
//   rd_resp_* : read response (valid/ready, data)
//   wr_req_*  : write request (valid/ready, address, bit mask, data)
//   sram_*    : RW0 macro pins (addr, en, wmode, wmask, wdata, rdata)
// Modports: slave = the controller, master = requesters plus the macro.
interface array_rw_ctrl_if
  import array_rw_pkg::*;
();

  logic              rd_req_valid;
  logic              rd_req_ready;
  logic [ADDR_W-1:0] rd_req_addr;
  logic              rd_resp_valid;
  logic              rd_resp_ready;
  logic [DATA_W-1:0] rd_resp_data;
  logic              wr_req_valid;
  logic              wr_req_ready;
  logic [ADDR_W-1:0] wr_req_addr;
  logic [DATA_W-1:0] wr_req_mask;
  logic [DATA_W-1:0] wr_req_data;
  logic [ADDR_W-1:0] sram_addr;
  logic              sram_en;
  logic              sram_wmode;
  logic [DATA_W-1:0] sram_wmask;
  logic [DATA_W-1:0] sram_wdata;
  logic [DATA_W-1:0] sram_rdata;

  modport slave (
    input  rd_req_valid, rd_req_addr, rd_resp_ready,
    input  wr_req_valid, wr_req_addr, wr_req_mask, wr_req_data,
    input  sram_rdata,
    output rd_req_ready, rd_resp_valid, rd_resp_data, wr_req_ready,
    output sram_addr, sram_en, sram_wmode, sram_wmask, sram_wdata
  );

  modport master (
    output rd_req_valid, rd_req_addr, rd_resp_ready,
    output wr_req_valid, wr_req_addr, wr_req_mask, wr_req_data,
    output sram_rdata,
    input  rd_req_ready, rd_resp_valid, rd_resp_data, wr_req_ready,
    input  sram_addr, sram_en, sram_wmode, sram_wmask, sram_wdata
  );

endinterface

// File: rtl/array_rd_hold.sv
// array_rd_hold: read response stage for a 1-cycle-latency macro.
//   clock, reset_n : clock, synchronous active-low reset
//   fire_i         : a read is issued to the macro this cycle
//   rdata_i        : macro read data (valid the cycle after fire_i)
//   rsp_ready_i    : consumer accepts the response
//   rsp_valid_o    : response valid
//   rsp_data_o     : response data (macro bypass, or held copy)
// The macro output is only trustworthy the cycle after the read, so an
// unaccepted response is copied into the hold register at the end of that
// cycle and served from there until the consumer takes it.
module array_rd_hold
  import array_rw_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic              fire_i,
  input  logic [DATA_W-1:0] rdata_i,
  input  logic              rsp_ready_i,
  output logic              rsp_valid_o,
  output logic [DATA_W-1:0] rsp_data_o
);

  logic              pend_q, pend_d;
  logic              hold_valid_q, hold_valid_d;
  logic [DATA_W-1:0] hold_data_q, hold_data_d;

  assign rsp_valid_o = pend_q || hold_valid_q;
  assign rsp_data_o  = hold_valid_q ? hold_data_q : rdata_i;

  // Next state of the pending flag and hold register.
  always_comb begin
    pend_d       = fire_i;
    hold_valid_d = hold_valid_q;
    hold_data_d  = hold_data_q;
    if (pend_q && !rsp_ready_i) begin
      hold_valid_d = 1'b1;
      hold_data_d  = rdata_i;
    end else if (hold_valid_q && rsp_ready_i) begin
      hold_valid_d = 1'b0;
    end else begin
      hold_valid_d = hold_valid_q;
    end
  end

  // Response state registers.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      pend_q       <= 1'b0;
      hold_valid_q <= 1'b0;
      hold_data_q  <= {DATA_W{1'b0}};
    end else begin
      pend_q       <= pend_d;
      hold_valid_q <= hold_valid_d;
      hold_data_q  <= hold_data_d;
    end
  end

endmodule

// File: rtl/array_rw_ctrl.sv
// array_rw_ctrl: merges read and write request channels onto the single RW0
// port of a 128x76 SRAM macro, one access per cycle.
//   clock, reset_n : clock, synchronous active-low reset
//   init_done      : controller is accepting requests
//   bus (slave)    : read/write request channels, read response, RW0 pins
// Writes always go through a one-entry buffer; the buffer drains when the
// port is free, on a read-after-write hazard, when a new write needs the
// slot, or after STARVE_LIMIT cycles of reads winning.
// Build option ARRAY_INIT_SWEEP_EN: when defined, the controller zero-fills
// the whole array (DEPTH cycles) after reset before entering RUN; otherwise
// it runs from the first cycle after reset release and contents are undefined.
module array_rw_ctrl
  import array_rw_pkg::*;
(
  input  logic            clock,
  input  logic            reset_n,
  output logic            init_done,
  array_rw_ctrl_if.slave  bus
);

  logic       run_s;
  logic       init_s;
  logic       drain_s;
  logic       rd_ready_s;
  logic       wr_ready_s;
  logic       rd_fire_s;
  logic       wr_acc_s;
  logic       rsp_valid_s;
  wbuf_t      wb_q, wb_d;
  logic       wb_valid_q, wb_valid_d;
  logic [1:0] starve_q, starve_d;

`ifdef ARRAY_INIT_SWEEP_EN
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  // Sweep FSM next state: INIT walks every address once, then RUN forever.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      INIT: begin
        cnt_d = cnt_q + {{(ADDR_W-1){1'b0}}, 1'b1};
        if (cnt_q == ADDR_W'(DEPTH - 1)) begin
          state_d = RUN;
        end else begin
          state_d = INIT;
        end
      end
      RUN: begin
        state_d = RUN;
      end
      default: begin
        state_d = INIT;
        cnt_d   = {ADDR_W{1'b0}};
      end
    endcase
  end

  // Sweep FSM state and address counter.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= INIT;
      cnt_q   <= {ADDR_W{1'b0}};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // reset_n gating keeps every output at its reset value while reset is held.
  assign run_s  = reset_n && (state_q == RUN);
  assign init_s = reset_n && (state_q == INIT);
`else
  assign run_s  = reset_n;
  assign init_s = 1'b0;
`endif

  assign init_done = run_s;

  // Decide whether the buffered write takes the port this cycle.
  always_comb begin
    drain_s = 1'b0;
    if (run_s && wb_valid_q) begin
      drain_s = !bus.rd_req_valid
             || (bus.rd_req_addr == wb_q.addr)
             || bus.wr_req_valid
             || (starve_q >= STARVE_LIMIT);
    end else begin
      drain_s = 1'b0;
    end
  end

  assign rd_ready_s       = run_s && !drain_s && (!rsp_valid_s || bus.rd_resp_ready);
  assign wr_ready_s       = run_s && (!wb_valid_q || drain_s);
  assign rd_fire_s        = bus.rd_req_valid && rd_ready_s;
  assign wr_acc_s         = bus.wr_req_valid && wr_ready_s;
  assign bus.rd_req_ready = rd_ready_s;
  assign bus.wr_req_ready = wr_ready_s;

  // Write buffer and starvation counter next state.
  always_comb begin
    wb_d       = wb_q;
    wb_valid_d = wb_valid_q;
    starve_d   = starve_q;
    if (wr_acc_s) begin
      wb_valid_d = 1'b1;
      wb_d.addr  = bus.wr_req_addr;
      wb_d.mask  = bus.wr_req_mask;
      wb_d.data  = bus.wr_req_data;
    end else if (drain_s) begin
      wb_valid_d = 1'b0;
    end else begin
      wb_valid_d = wb_valid_q;
    end
    // Counts cycles the buffered write was passed over; a fresh entry starts at 0.
    if (!wb_valid_q || drain_s) begin
      starve_d = 2'd0;
    end else if (starve_q < STARVE_LIMIT) begin
      starve_d = starve_q + 2'd1;
    end else begin
      starve_d = starve_q;
    end
  end

  // Write buffer and starvation counter registers.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wb_valid_q <= 1'b0;
      wb_q       <= '{addr: {ADDR_W{1'b0}}, mask: {DATA_W{1'b0}}, data: {DATA_W{1'b0}}};
      starve_q   <= 2'd0;
    end else begin
      wb_valid_q <= wb_valid_d;
      wb_q       <= wb_d;
      starve_q   <= starve_d;
    end
  end

  // RW0 port drive: sweep write, buffered write, read, or idle (exclusive).
  always_comb begin
    bus.sram_en    = 1'b0;
    bus.sram_wmode = 1'b0;
    bus.sram_addr  = {ADDR_W{1'b0}};
    bus.sram_wmask = {DATA_W{1'b0}};
    bus.sram_wdata = {DATA_W{1'b0}};
    if (init_s) begin
      bus.sram_en    = 1'b1;
      bus.sram_wmode = 1'b1;
      bus.sram_wmask = {DATA_W{1'b1}};
`ifdef ARRAY_INIT_SWEEP_EN
      bus.sram_addr  = cnt_q;
`endif
    end else if (drain_s) begin
      bus.sram_en    = 1'b1;
      bus.sram_wmode = 1'b1;
      bus.sram_addr  = wb_q.addr;
      bus.sram_wmask = wb_q.mask;
      bus.sram_wdata = wb_q.data;
    end else if (rd_fire_s) begin
      bus.sram_en    = 1'b1;
      bus.sram_addr  = bus.rd_req_addr;
    end else begin
      bus.sram_en    = 1'b0;
    end
  end

  array_rd_hold u_rd_hold (
    .clock       (clock),
    .reset_n     (reset_n),
    .fire_i      (rd_fire_s),
    .rdata_i     (bus.sram_rdata),
    .rsp_ready_i (bus.rd_resp_ready),
    .rsp_valid_o (rsp_valid_s),
    .rsp_data_o  (bus.rd_resp_data)
  );

  assign bus.rd_resp_valid = rsp_valid_s;

endmodule
